// File: rtl/cipher_dp.sv
// cipher_dp: key-generation state machine plus a byte encode/decode datapath.
// The key is built from two KEYGEN commands: the first loads the seed, the
// second advances it one LFSR step. ENCODE/DECODE only run once the key is
// ready; otherwise they flag cmd_err and leave dout untouched.
module cipher_dp #(
  parameter int unsigned ROT = 3
) (
  input  logic       clka,
  input  logic       restart,
  input  logic       key_gen,
  input  logic       outcode,
  input  logic [7:0] seed,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       key_ready,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    StIdle,
    StSeeded,
    StReady
  } key_state_e;

  key_state_e state_q, state_d;
  logic [7:0] key_q, key_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       key_ready_q, key_ready_d;
  logic       cmd_err_q, cmd_err_d;

  function automatic logic [7:0] lfsr_step(input logic [7:0] k);
    return {k[6:0], k[7] ^ k[5] ^ k[4] ^ k[3]};
  endfunction

  // Rotate via a doubled byte so the shift amount never wraps past the width.
  function automatic logic [7:0] rotl8(input logic [7:0] x);
    logic [15:0] sh;
    sh = {x, x} << ROT;
    return sh[15:8];
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] x);
    logic [15:0] sh;
    sh = {x, x} >> ROT;
    return sh[7:0];
  endfunction

  // Next-state decode of the {key_gen, outcode} command.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    cmd_err_d    = 1'b0;
    case ({key_gen, outcode})
      2'b10: begin
        if (state_q == StSeeded) begin
          key_d   = lfsr_step(key_q);
          state_d = StReady;
        end else begin
          // An all-zero seed would lock the LFSR at zero.
          key_d   = (seed == 8'h00) ? 8'h01 : seed;
          state_d = StSeeded;
        end
      end
      2'b01: begin
        if (state_q == StReady) begin
          dout_d       = rotl8(din ^ key_q);
          dout_valid_d = 1'b1;
        end else begin
          cmd_err_d = 1'b1;
        end
      end
      2'b11: begin
        if (state_q == StReady) begin
          dout_d       = rotr8(din) ^ key_q;
          dout_valid_d = 1'b1;
        end else begin
          cmd_err_d = 1'b1;
        end
      end
      default: ;
    endcase
    key_ready_d = (state_d == StReady);
  end

  // State and registered outputs; restart clears everything immediately.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q      <= StIdle;
      key_q        <= 8'h00;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      key_ready_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      key_ready_q  <= key_ready_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign key_ready  = key_ready_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_cipher_dp.sv
// Directed bench for cipher_dp with hand-computed vectors (ROT = 3).
module tb_cipher_dp;

  logic       clka;
  logic       restart;
  logic       key_gen;
  logic       outcode;
  logic [7:0] seed;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       key_ready;
  logic       cmd_err;

  int n_checks;
  int n_errors;

  cipher_dp #(
    .ROT(3)
  ) u_dut (
    .clka      (clka),
    .restart   (restart),
    .key_gen   (key_gen),
    .outcode   (outcode),
    .seed      (seed),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid),
    .key_ready (key_ready),
    .cmd_err   (cmd_err)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Present one command, let one rising edge take it, then return to NOP.
  task automatic do_cmd(input logic kg, input logic oc, input logic [7:0] s, input logic [7:0] d);
    key_gen = kg;
    outcode = oc;
    seed    = s;
    din     = d;
    @(posedge clka);
    #1;
    key_gen = 1'b0;
    outcode = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    restart  = 1'b1;
    key_gen  = 1'b0;
    outcode  = 1'b0;
    seed     = 8'h00;
    din      = 8'h00;

    // Reset values, before the first clock edge.
    #2;
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_valid", {7'd0, dout_valid}, 8'h00);
    check_eq("rst_ready", {7'd0, key_ready}, 8'h00);
    check_eq("rst_err", {7'd0, cmd_err}, 8'h00);

    // Commands are ignored while restart is held.
    do_cmd(1'b1, 1'b0, 8'h3C, 8'h00);
    do_cmd(1'b1, 1'b0, 8'h3C, 8'h00);
    check_eq("rst_hold_ready", {7'd0, key_ready}, 8'h00);
    @(negedge clka);
    restart = 1'b0;

    // ENCODE straight after reset.
    do_cmd(1'b0, 1'b1, 8'h00, 8'hAA);
    check_eq("enc_idle_err", {7'd0, cmd_err}, 8'h01);
    check_eq("enc_idle_valid", {7'd0, dout_valid}, 8'h00);
    check_eq("enc_idle_dout", dout, 8'h00);
    do_cmd(1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("err_pulse_end", {7'd0, cmd_err}, 8'h00);

    // Single KEYGEN then ENCODE: still not ready.
    do_cmd(1'b1, 1'b0, 8'h3C, 8'h00);
    check_eq("seeded_ready", {7'd0, key_ready}, 8'h00);
    do_cmd(1'b0, 1'b1, 8'h00, 8'h5A);
    check_eq("enc_seeded_err", {7'd0, cmd_err}, 8'h01);
    check_eq("enc_seeded_dout", dout, 8'h00);

    // Second KEYGEN: key = 79.
    do_cmd(1'b1, 1'b0, 8'hFF, 8'h00);
    check_eq("ready_3c", {7'd0, key_ready}, 8'h01);

    // ENCODE 5A -> rotl(5A^79,3) = rotl(23,3) = 19.
    do_cmd(1'b0, 1'b1, 8'h00, 8'h5A);
    check_eq("enc_dout", dout, 8'h19);
    check_eq("enc_valid", {7'd0, dout_valid}, 8'h01);
    check_eq("enc_err", {7'd0, cmd_err}, 8'h00);
    do_cmd(1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("valid_pulse_end", {7'd0, dout_valid}, 8'h00);
    check_eq("dout_hold", dout, 8'h19);

    // DECODE 19 -> rotr(19,3)^79 = 23^79 = 5A.
    do_cmd(1'b1, 1'b1, 8'h00, 8'h19);
    check_eq("dec_dout", dout, 8'h5A);
    check_eq("dec_valid", {7'd0, dout_valid}, 8'h01);

    // Back-to-back ENCODE then DECODE.
    do_cmd(1'b0, 1'b1, 8'h00, 8'h5A);
    check_eq("b2b_enc_dout", dout, 8'h19);
    check_eq("b2b_enc_valid", {7'd0, dout_valid}, 8'h01);
    do_cmd(1'b1, 1'b1, 8'h00, 8'h19);
    check_eq("b2b_dec_dout", dout, 8'h5A);
    check_eq("b2b_dec_valid", {7'd0, dout_valid}, 8'h01);
    check_eq("b2b_ready_kept", {7'd0, key_ready}, 8'h01);

    // Re-key from READY with seed 00: key = lfsr(01) = 02.
    do_cmd(1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("rekey_seeded", {7'd0, key_ready}, 8'h00);
    do_cmd(1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("ready_00", {7'd0, key_ready}, 8'h01);
    // ENCODE 00 -> rotl(02,3) = 10.
    do_cmd(1'b0, 1'b1, 8'h00, 8'h00);
    check_eq("enc_key02", dout, 8'h10);
    // ENCODE 5A -> rotl(58,3) = C2.
    do_cmd(1'b0, 1'b1, 8'h00, 8'h5A);
    check_eq("enc_key02_b", dout, 8'hC2);
    check_eq("enc_key02_valid", {7'd0, dout_valid}, 8'h01);

    // Asynchronous restart while READY, between two ENCODEs.
    restart = 1'b1;
    #1;
    check_eq("async_dout", dout, 8'h00);
    check_eq("async_valid", {7'd0, dout_valid}, 8'h00);
    check_eq("async_ready", {7'd0, key_ready}, 8'h00);
    @(negedge clka);
    restart = 1'b0;
    do_cmd(1'b0, 1'b1, 8'h00, 8'h5A);
    check_eq("post_rst_err", {7'd0, cmd_err}, 8'h01);
    check_eq("post_rst_valid", {7'd0, dout_valid}, 8'h00);
    check_eq("post_rst_dout", dout, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cipher_dp.md
CIPHER_DP -- requirements
Module: cipher_dp

Interface
REQ-001 Parameter ROT, default 3, rotate amount for encode/decode; legal range 1..7.
REQ-002 clka  input  1  sole clock; all state updates on rising edge.
REQ-003 restart  input  1  asynchronous, active-high reset.
REQ-004 key_gen  input  1  command bit from controller (key-generation request).
REQ-005 outcode  input  1  command bit from controller (output-code request).
REQ-006 seed  input  8  key seed, sampled on seed-load cycles.
REQ-007 din  input  8  plaintext (encode) or ciphertext (decode), sampled on encode/decode cycles.
REQ-008 dout  output  8  registered result.
REQ-009 dout_valid  output  1  one-cycle pulse; dout updated this cycle.
REQ-010 key_ready  output  1  high while the key state is READY.
REQ-011 cmd_err  output  1  one-cycle pulse; encode/decode requested without a ready key.

Function
REQ-012 Command decoding, evaluated every rising edge: {key_gen,outcode} = 00 NOP, 10 KEYGEN, 01 ENCODE, 11 DECODE.
REQ-013 Key state machine states: IDLE, SEEDED, READY.
REQ-014 KEYGEN in IDLE or READY: key <= seed (seed==8'h00 substituted by 8'h01); state -> SEEDED.
REQ-015 KEYGEN in SEEDED: key <= lfsr(key); state -> READY.
REQ-016 lfsr(k) = {k[6:0], k[7]^k[5]^k[4]^k[3]}.
REQ-017 NOP in any state: key and state unchanged.
REQ-018 ENCODE in READY: dout <= rotl(din ^ key, ROT); dout_valid pulses high for exactly the following cycle.
REQ-019 DECODE in READY: dout <= rotr(din, ROT) ^ key; dout_valid pulses likewise.
REQ-020 Key and state are unchanged by ENCODE/DECODE; back-to-back ENCODE/DECODE cycles each produce one result and one dout_valid pulse.
REQ-021 ENCODE/DECODE in IDLE or SEEDED: dout is held, dout_valid stays 0, cmd_err pulses high for one cycle, and state is unchanged.
REQ-022 Latency: a command sampled at edge N is reflected on dout/dout_valid/cmd_err/key_ready after edge N.
REQ-023 dout holds its last value between results.
REQ-024 key_ready = (state == READY), driven from a register.

Reset
REQ-025 restart asserted forces immediately, without waiting for clka: state = IDLE, key = 8'h00, dout = 8'h00, dout_valid = 0, key_ready = 0, cmd_err = 0.
REQ-026 restart asserted mid-sequence (SEEDED or READY) discards the key; the next ENCODE/DECODE before a full KEYGEN pair raises cmd_err.
REQ-027 While restart is high, commands are ignored.
REQ-028 Deassertion is sampled at clka rising edges; the first command is accepted at the first edge after restart falls.

Verification
REQ-029 Reset -> all outputs 0 and key_ready 0, checked asynchronously before any clka edge.
REQ-030 seed=8'h3C, two KEYGEN cycles, ENCODE with din=8'h5A (ROT=3) -> key=8'h79, key_ready=1, dout=8'h19, dout_valid pulse of one cycle.
REQ-031 Same key, DECODE with din=8'h19 -> dout=8'h5A; then ENCODE/DECODE back-to-back -> two consecutive dout_valid cycles.
REQ-032 ENCODE straight after reset, and ENCODE after a single KEYGEN -> cmd_err pulse each time, dout_valid=0, dout unchanged.
REQ-033 seed=8'h00, two KEYGEN cycles -> key=8'h02, key_ready=1.
REQ-034 restart pulsed while READY, between two ENCODE cycles -> outputs clear asynchronously; the following ENCODE gives cmd_err=1.
